// File: rtl/vend_seq_ctrl.sv
// Vending transaction sequencer: collects coins against a latched price, times the
// dispense output, then pays change one coin at a time and keeps any sub-coin credit.
module vend_seq_ctrl #(
    parameter int W           = 8,
    parameter int CHANGE_VAL  = 25,
    parameter int DISP_CYC    = 5,
    parameter int TIMEOUT_CYC = 50
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         coin_i,
    input  logic [W-1:0] coin_val_i,
    input  logic [W-1:0] price_i,
    input  logic         cancel_i,
    output logic [W-1:0] total_o,
    output logic         disp_o,
    output logic         change_o,
    output logic         reject_o,
    output logic         busy_o
);

    localparam int CNT_MAX = (DISP_CYC > TIMEOUT_CYC) ? DISP_CYC : TIMEOUT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [W-1:0] CV_W  = W'(CHANGE_VAL);
    localparam logic [W:0]   CV_W1 = (W+1)'(CHANGE_VAL);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE} state_t;

    state_t        r_state, w_state_next;
    logic [W-1:0]  r_total, w_total_next;
    logic [W-1:0]  r_price, w_price_next;
    logic [W-1:0]  r_rem,   w_rem_next;
    logic [CW-1:0] r_cnt,   w_cnt_next;
    logic          r_gap,   w_gap_next;
    logic          r_disp,  w_disp_next;
    logic          r_change, w_change_next;
    logic          r_reject, w_reject_next;
    logic          r_busy,  w_busy_next;

    logic [W:0]    w_sum;
    logic          w_fits;
    logic [W-1:0]  w_total_acc;
    logic          w_paid;
    logic          w_timeout;
    logic          w_refund;
    logic          w_disp_last;
    logic          w_can_pay;

    // Overflow is detected in W+1 bits; a coin that does not fit leaves credit untouched.
    assign w_sum       = {1'b0, r_total} + {1'b0, coin_val_i};
    assign w_fits      = ~w_sum[W];
    assign w_total_acc = (coin_i && w_fits) ? w_sum[W-1:0] : r_total;
    assign w_paid      = (r_total >= r_price);
    assign w_timeout   = !coin_i && (r_cnt == CW'(TIMEOUT_CYC - 1));
    assign w_refund    = cancel_i || w_timeout;
    assign w_disp_last = (r_cnt == CW'(DISP_CYC - 1));
    assign w_can_pay   = ({1'b0, r_rem} >= CV_W1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_total  <= '0;
            r_price  <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_gap    <= 1'b0;
            r_disp   <= 1'b0;
            r_change <= 1'b0;
            r_reject <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_total  <= w_total_next;
            r_price  <= w_price_next;
            r_rem    <= w_rem_next;
            r_cnt    <= w_cnt_next;
            r_gap    <= w_gap_next;
            r_disp   <= w_disp_next;
            r_change <= w_change_next;
            r_reject <= w_reject_next;
            r_busy   <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cancel_i && (w_total_acc != '0)) w_state_next = S_CHANGE;
                else if (coin_i)                     w_state_next = S_COLLECT;
            end
            S_COLLECT: begin
                // A satisfied price wins over a cancel or timeout in the same cycle.
                if (w_paid)        w_state_next = S_DISPENSE;
                else if (w_refund) w_state_next = S_CHANGE;
            end
            S_DISPENSE: begin
                if (w_disp_last) w_state_next = S_CHANGE;
            end
            S_CHANGE: begin
                if (!r_gap && !w_can_pay) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_total_next  = r_total;
        w_price_next  = r_price;
        w_rem_next    = r_rem;
        w_cnt_next    = r_cnt;
        w_gap_next    = 1'b0;
        w_change_next = 1'b0;
        w_reject_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_total_next  = w_total_acc;
                w_reject_next = coin_i && !w_fits;
                w_cnt_next    = '0;
                if (coin_i)   w_price_next = price_i;
                if (cancel_i) w_rem_next   = w_total_acc;
            end
            S_COLLECT: begin
                if (w_paid) begin
                    w_rem_next    = r_total - r_price;
                    w_total_next  = r_total - r_price;
                    w_cnt_next    = '0;
                    w_reject_next = coin_i;
                end else begin
                    w_total_next  = w_total_acc;
                    w_reject_next = coin_i && !w_fits;
                    w_cnt_next    = coin_i ? '0 : r_cnt + 1'b1;
                    if (w_refund) w_rem_next = w_total_acc;
                end
            end
            S_DISPENSE: begin
                w_reject_next = coin_i;
                w_cnt_next    = r_cnt + 1'b1;
            end
            S_CHANGE: begin
                w_reject_next = coin_i;
                // Every pulse is followed by one forced low cycle.
                if (!r_gap) begin
                    if (w_can_pay) begin
                        w_change_next = 1'b1;
                        w_rem_next    = r_rem - CV_W;
                        w_total_next  = r_rem - CV_W;
                        w_gap_next    = 1'b1;
                    end else begin
                        w_total_next  = r_rem;
                    end
                end
            end
            default: ;
        endcase
        w_disp_next = (w_state_next == S_DISPENSE);
        w_busy_next = (w_state_next == S_DISPENSE) || (w_state_next == S_CHANGE);
    end

    assign total_o  = r_total;
    assign disp_o   = r_disp;
    assign change_o = r_change;
    assign reject_o = r_reject;
    assign busy_o   = r_busy;

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Randomized bench for vend_seq_ctrl; expectations come from a coin-and-credit
// arithmetic model of each transaction (sale, refund, timeout, reject, reset).
module tb_vend_seq_ctrl;

    localparam int W   = 8;
    localparam int CV  = 25;
    localparam int DC  = 5;
    localparam int TO  = 50;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         coin;
    logic [W-1:0] coin_val;
    logic [W-1:0] price;
    logic         cancel;
    logic [W-1:0] total_o;
    logic         disp_o, change_o, reject_o, busy_o;

    vend_seq_ctrl #(.W(W), .CHANGE_VAL(CV), .DISP_CYC(DC), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .coin_i(coin), .coin_val_i(coin_val),
        .price_i(price), .cancel_i(cancel), .total_o(total_o), .disp_o(disp_o),
        .change_o(change_o), .reject_o(reject_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int m_credit = 0;

    int o_disp, o_first_disp, o_chg, o_first_chg, o_last_chg, o_adj;
    bit o_prev_chg, o_seen_busy;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr_obs();
        o_disp = 0; o_first_disp = -1; o_chg = 0; o_first_chg = -1;
        o_last_chg = -1; o_adj = 0; o_prev_chg = 1'b0; o_seen_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        if (disp_o) begin
            if (o_first_disp < 0) o_first_disp = cyc;
            o_disp++;
        end
        if (change_o) begin
            if (o_first_chg < 0) o_first_chg = cyc;
            o_last_chg = cyc;
            o_chg++;
            if (o_prev_chg) o_adj++;
        end
        o_prev_chg = change_o;
        if (busy_o) o_seen_busy = 1'b1;
    endtask

    function automatic int rand_coin();
        int vals[7];
        vals = '{0, 5, 10, 25, 50, 75, 100};
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, MAXV));
        return vals[$urandom_range(0, 6)];
    endfunction

    // Run until the machine has been busy and is idle again, then check the totals.
    task automatic watch(input string name, input int exp_first_disp, input int exp_disp, input int refund);
        for (int k = 0; k < 600; k++) begin
            if (o_seen_busy && !busy_o) break;
            tick();
        end
        chk({name, "_idle_reached"}, int'(o_seen_busy && !busy_o), 1);
        chk({name, "_disp_cycles"}, o_disp, exp_disp);
        if (exp_disp > 0) chk({name, "_disp_start"}, o_first_disp, exp_first_disp);
        chk({name, "_change_pulses"}, o_chg, refund / CV);
        chk({name, "_change_gap"}, o_adj, 0);
        chk({name, "_credit"}, int'(total_o), refund % CV);
        $display("txn %s: refund/change %0d -> pulses %0d, disp %0d, credit %0d",
                 name, refund, o_chg, o_disp, total_o);
        m_credit = refund % CV;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; coin = 1'b0; cancel = 1'b0; coin_val = '0; price = '0;
        #23;
        rst_ni = 1'b1;
        tick();
        m_credit = 0;
        chk("rst_total", int'(total_o), 0);
        chk("rst_disp", int'(disp_o), 0);
        chk("rst_change", int'(change_o), 0);
        chk("rst_reject", int'(reject_o), 0);
        chk("rst_busy", int'(busy_o), 0);
    endtask

    task automatic do_sale(input string name, input int p, input int vals[$], input bit poke);
        int c, v, tpay;
        bit paid, rej;
        clr_obs();
        c = m_credit; paid = 1'b0; tpay = 0;
        price = W'(p);
        for (int n = 0; n < 40 && !paid; n++) begin
            v = (vals.size() > 0) ? vals.pop_front() : rand_coin();
            coin = 1'b1; coin_val = W'(v);
            tick();
            coin = 1'b0;
            price = W'($urandom_range(0, MAXV));
            rej = (c + v > MAXV);
            if (!rej) c += v;
            chk({name, "_total"}, int'(total_o), c);
            chk({name, "_reject"}, int'(reject_o), int'(rej));
            if (c >= p) begin
                paid = 1'b1; tpay = cyc;
            end else begin
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        if (!paid) begin
            cancel = 1'b1; tick(); cancel = 1'b0;
            watch({name, "_unpaid"}, 0, 0, c);
        end else begin
            if (poke) begin
                tick();
                coin = 1'b1; coin_val = W'(rand_coin()); cancel = 1'b1;
                tick();
                coin = 1'b0; cancel = 1'b0;
                chk({name, "_disp_reject"}, int'(reject_o), 1);
                chk({name, "_disp_total"}, int'(total_o), c - p);
            end
            watch(name, tpay + 1, DC, c - p);
        end
    endtask

    // Price is held at the maximum so collected credit can never complete a sale.
    task automatic do_cancel(input string name, input int vals[$], input bit same);
        int c, v, n;
        clr_obs();
        c = m_credit;
        price = W'(MAXV);
        n = vals.size();
        for (int i = 0; i < n; i++) begin
            v = vals.pop_front();
            coin = 1'b1; coin_val = W'(v);
            if (same && i == n - 1) cancel = 1'b1;
            tick();
            coin = 1'b0; cancel = 1'b0;
            c += v;
            chk({name, "_total"}, int'(total_o), c);
            if (i < n - 1) repeat ($urandom_range(0, 2)) tick();
        end
        if (!same) begin
            repeat ($urandom_range(0, 3)) tick();
            cancel = 1'b1; tick(); cancel = 1'b0;
        end
        watch(name, 0, 0, c);
    endtask

    task automatic do_timeout();
        int c, t0;
        clr_obs();
        c = m_credit + 50;
        price = 8'd100;
        coin = 1'b1; coin_val = 8'd50;
        tick();
        coin = 1'b0;
        t0 = cyc;
        watch("timeout", 0, 0, c);
        chk("timeout_first_pulse", o_first_chg, t0 + TO + 1);
        chk("timeout_pulse_span", o_last_chg - o_first_chg, 2 * (c / CV - 1));
    endtask

    task automatic do_overflow_reject();
        int q[$];
        clr_obs();
        q = '{100, 100, 50};
        price = W'(MAXV);
        foreach (q[i]) begin
            coin = 1'b1; coin_val = W'(q[i]); tick(); coin = 1'b0;
        end
        chk("ovf_total_before", int'(total_o), m_credit + 250);
        coin = 1'b1; coin_val = 8'd10; tick(); coin = 1'b0;
        chk("ovf_reject", int'(reject_o), 1);
        chk("ovf_total_after", int'(total_o), m_credit + 250);
        tick();
        chk("ovf_reject_single", int'(reject_o), 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        watch("ovf_refund", 0, 0, m_credit + 250);
    endtask

    task automatic do_reset_mid_change();
        int c;
        clr_obs();
        c = m_credit + 100;
        price = W'(MAXV);
        coin = 1'b1; coin_val = 8'd100; tick(); coin = 1'b0;
        cancel = 1'b1; tick(); cancel = 1'b0;
        for (int k = 0; k < 10 && !change_o; k++) tick();
        chk("rstmid_pulse_seen", int'(change_o), 1);
        tick();
        chk("rstmid_pre_busy", int'(busy_o), 1);
        chk("rstmid_pre_total", int'(total_o), c - CV);
        #3 rst_ni = 1'b0;
        #1;
        chk("rstmid_total", int'(total_o), 0);
        chk("rstmid_busy", int'(busy_o), 0);
        chk("rstmid_change", int'(change_o), 0);
        chk("rstmid_disp", int'(disp_o), 0);
        chk("rstmid_reject", int'(reject_o), 0);
        @(posedge clk); #3 rst_ni = 1'b1;
        repeat (3) tick();
        chk("rstmid_after_total", int'(total_o), 0);
        chk("rstmid_after_change", o_chg, 1);
        m_credit = 0;
        $display("txn reset_mid_change: outputs cleared, credit 0");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        do_reset();

        q = '{50, 50};  do_sale("exact", 100, q, 1'b0);
        q = '{50, 75};  do_sale("overpay", 100, q, 1'b0);
        q = '{50, 60};  do_sale("overpay_credit", 100, q, 1'b0);
        chk("credit_kept", int'(total_o), 10);

        do_reset();
        q = '{25, 25, 10}; do_cancel("cancel", q, 1'b0);
        q = '{20, 30};     do_cancel("cancel_same", q, 1'b1);
        do_reset_mid_change();
        do_timeout();
        do_overflow_reject();
        q = '{0};          do_sale("price_zero", 0, q, 1'b0);
        q = '{50, 50};     do_sale("disp_poke", 80, q, 1'b1);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    q = {};
                    do_sale($sformatf("rsale%0d", t), int'($urandom_range(0, 200)), q,
                            1'($urandom_range(0, 1)));
                end
                2: begin
                    q = {};
                    repeat ($urandom_range(1, 4)) q.push_back(int'($urandom_range(0, 50)));
                    do_cancel($sformatf("rcancel%0d", t), q, 1'($urandom_range(0, 1)));
                end
                default: begin
                    clr_obs();
                    cancel = 1'b1; tick(); cancel = 1'b0;
                    if (m_credit > 0) begin
                        watch($sformatf("ridle%0d", t), 0, 0, m_credit);
                    end else begin
                        tick();
                        chk("idle_cancel0_busy", int'(busy_o), 0);
                        chk("idle_cancel0_total", int'(total_o), 0);
                        $display("txn ridle%0d: cancel with no credit ignored", t);
                    end
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
